// File: rtl/morse_key_timer.sv
// Morse key front end: synchronises and debounces the raw key, times presses and gaps
// against the tick strobe, and packs dots/dashes into a per-letter pattern.
module morse_key_timer #(
    parameter int DEBOUNCE_TICKS   = 4,
    parameter int DASH_TICKS       = 12,
    parameter int LETTER_GAP_TICKS = 30,
    parameter int MAX_PRESS_TICKS  = 60,
    parameter int MAX_SYMBOLS      = 5,
    parameter int CNT_W            = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       key_in,
    output logic                       key_db,
    output logic                       sym_valid,
    output logic                       sym_dash,
    output logic                       letter_valid,
    output logic [2*MAX_SYMBOLS-1:0]   letter_code,
    output logic [2:0]                 letter_count,
    output logic                       letter_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS    = 2'd1,
        GAP      = 2'd2,
        OVERLONG = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] DASH_LIM   = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(MAX_PRESS_TICKS - 1);
    localparam logic [CNT_W-1:0] PRESS_MAX  = CNT_W'(MAX_PRESS_TICKS);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(LETTER_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_MAX    = CNT_W'(LETTER_GAP_TICKS);
    localparam logic [2:0]       SYM_MAX    = 3'(MAX_SYMBOLS);

    state_t                     state_r;
    logic                       key_s1_r;
    logic                       key_s2_r;
    logic                       key_db_r;
    logic                       key_db_d_r;
    logic [CNT_W-1:0]           deb_cnt_r;
    logic [CNT_W-1:0]           press_cnt_r;
    logic [CNT_W-1:0]           gap_cnt_r;
    logic [2*MAX_SYMBOLS-1:0]   acc_code_r;
    logic [2:0]                 acc_count_r;
    logic                       acc_err_r;
    logic                       rise_s;
    logic                       fall_s;
    logic                       dash_s;
    logic [1:0]                 slot_s;

    assign key_db = key_db_r;
    assign rise_s = key_db_r & ~key_db_d_r;
    assign fall_s = ~key_db_r & key_db_d_r;
    assign dash_s = (press_cnt_r >= DASH_LIM);
    assign slot_s = dash_s ? 2'b10 : 2'b01;

    // Two-flop synchroniser, debounce counter and edge-detect delay
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1_r   <= 1'b0;
            key_s2_r   <= 1'b0;
            key_db_r   <= 1'b0;
            key_db_d_r <= 1'b0;
            deb_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            key_s1_r   <= key_in;
            key_s2_r   <= key_s1_r;
            key_db_d_r <= key_db_r;
            if (key_s2_r == key_db_r) begin
                deb_cnt_r <= {CNT_W{1'b0}};
            end else if (tick) begin
                if (deb_cnt_r >= DEB_LAST) begin
                    key_db_r  <= ~key_db_r;
                    deb_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    deb_cnt_r <= deb_cnt_r + CNT_W'(1);
                end
            end else begin
                deb_cnt_r <= deb_cnt_r;
            end
        end
    end

    // Symbol/letter FSM; edges outrank a coincident tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            press_cnt_r  <= {CNT_W{1'b0}};
            gap_cnt_r    <= {CNT_W{1'b0}};
            acc_code_r   <= {(2*MAX_SYMBOLS){1'b0}};
            acc_count_r  <= 3'd0;
            acc_err_r    <= 1'b0;
            sym_valid    <= 1'b0;
            sym_dash     <= 1'b0;
            letter_valid <= 1'b0;
            letter_code  <= {(2*MAX_SYMBOLS){1'b0}};
            letter_count <= 3'd0;
            letter_err   <= 1'b0;
        end else begin
            sym_valid    <= 1'b0;
            sym_dash     <= 1'b0;
            letter_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r     <= PRESS;
                        press_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                PRESS: begin
                    if (fall_s) begin
                        sym_valid <= 1'b1;
                        sym_dash  <= dash_s;
                        if (acc_count_r >= SYM_MAX) begin
                            acc_err_r <= 1'b1;
                        end else begin
                            acc_code_r  <= {acc_code_r[2*MAX_SYMBOLS-3:0], slot_s};
                            acc_count_r <= acc_count_r + 3'd1;
                        end
                        state_r   <= GAP;
                        gap_cnt_r <= {CNT_W{1'b0}};
                    end else if (tick) begin
                        if (press_cnt_r >= PRESS_LAST) begin
                            press_cnt_r <= PRESS_MAX;
                            acc_code_r  <= {(2*MAX_SYMBOLS){1'b0}};
                            acc_count_r <= 3'd0;
                            acc_err_r   <= 1'b0;
                            state_r     <= OVERLONG;
                        end else begin
                            press_cnt_r <= press_cnt_r + CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (rise_s) begin
                        state_r     <= PRESS;
                        press_cnt_r <= {CNT_W{1'b0}};
                    end else if (tick) begin
                        if (gap_cnt_r >= GAP_LAST) begin
                            gap_cnt_r    <= GAP_MAX;
                            letter_valid <= 1'b1;
                            letter_code  <= acc_code_r;
                            letter_count <= acc_count_r;
                            letter_err   <= acc_err_r;
                            acc_code_r   <= {(2*MAX_SYMBOLS){1'b0}};
                            acc_count_r  <= 3'd0;
                            acc_err_r    <= 1'b0;
                            state_r      <= IDLE;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + CNT_W'(1);
                        end
                    end
                end
                OVERLONG: begin
                    if (fall_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_timer.sv
// Randomised bench for morse_key_timer: a press/gap-level letter model predicts every
// symbol and letter, and a negedge monitor compares the DUT pulses against it.
module tb_morse_key_timer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       key_in;
    logic       key_db;
    logic       sym_valid;
    logic       sym_dash;
    logic       letter_valid;
    logic [9:0] letter_code;
    logic [2:0] letter_count;
    logic       letter_err;

    typedef struct packed {
        logic [9:0] code;
        logic [2:0] count;
        logic       err;
    } letter_t;

    int      vectors;
    int      miscompares;
    int      rises;
    logic    key_db_prev;
    bit      exp_sym[$];
    letter_t exp_let[$];
    bit      cur_dash[$];
    bit      cur_err;
    letter_t last_let;

    morse_key_timer dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .key_in       (key_in),
        .key_db       (key_db),
        .sym_valid    (sym_valid),
        .sym_dash     (sym_dash),
        .letter_valid (letter_valid),
        .letter_code  (letter_code),
        .letter_count (letter_count),
        .letter_err   (letter_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a press of len ticks becomes a dot/dash, >= 60 aborts the letter;
    // a release of >= 30 ticks closes a non-empty letter.
    task automatic model_press(input int len);
        if (len >= 60) begin
            cur_dash.delete();
            cur_err = 1'b0;
        end else begin
            exp_sym.push_back(len >= 12);
            if (cur_dash.size() < 5) cur_dash.push_back(len >= 12);
            else cur_err = 1'b1;
        end
    endtask

    task automatic model_release(input int len);
        letter_t l;
        int n;
        if (len >= 30 && cur_dash.size() > 0) begin
            n = cur_dash.size();
            l.code = 10'd0;
            for (int k = 0; k < n; k++)
                l.code = l.code | ((cur_dash[k] ? 10'd2 : 10'd1) << (2 * (n - 1 - k)));
            l.count = 3'(n);
            l.err = cur_err;
            exp_let.push_back(l);
            last_let = l;
            cur_dash.delete();
            cur_err = 1'b0;
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    endtask

    task automatic key(input logic level, input int n);
        key_in = level;
        run_ticks(n);
    endtask

    task automatic press_sym(input int p, input int g);
        model_press(p);
        key(1'b1, p);
        model_release(g);
        key(1'b0, g);
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_code"}, letter_code, last_let.code);
        chk({tag, "_count"}, letter_count, last_let.count);
        chk({tag, "_err"}, letter_err, last_let.err);
        chk({tag, "_sym_left"}, exp_sym.size(), 0);
        chk({tag, "_let_left"}, exp_let.size(), 0);
    endtask

    // Monitor: every pulse must match the head of the model queues
    always @(negedge clk) begin
        if (!reset) begin
            if (key_db && !key_db_prev) rises++;
            key_db_prev = key_db;
            if (sym_valid) begin
                chk("sym_expected", exp_sym.size() > 0, 1);
                if (exp_sym.size() > 0) chk("sym_dash", sym_dash, exp_sym.pop_front());
            end
            if (letter_valid) begin
                chk("letter_expected", exp_let.size() > 0, 1);
                if (exp_let.size() > 0) begin
                    letter_t e;
                    e = exp_let.pop_front();
                    chk("letter_code", letter_code, e.code);
                    chk("letter_count", letter_count, e.count);
                    chk("letter_err", letter_err, e.err);
                end
            end
        end else begin
            key_db_prev = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nsym;
        int p;
        int g;
        int r0;
        vectors     = 0;
        miscompares = 0;
        rises       = 0;
        key_db_prev = 1'b0;
        cur_err     = 1'b0;
        last_let    = '0;
        reset  = 1'b1;
        tick   = 1'b0;
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_ticks(100);
        chk("rst_key_db", key_db, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym_dash", sym_dash, 0);
        chk("rst_letter_valid", letter_valid, 0);
        chk_held("rst");

        // "A": dot then dash
        press_sym(5, 5);
        press_sym(20, 40);
        chk_held("A");
        chk("A_code_const", letter_code, 10'b0000000110);
        chk("A_count_const", letter_count, 3'd2);

        // Bounce on the leading edge yields one clean dot
        r0 = rises;
        model_press(9);
        key(1'b1, 1);
        key(1'b0, 1);
        key(1'b1, 1);
        key(1'b1, 8);
        model_release(40);
        key(1'b0, 40);
        chk("bounce_rises", rises - r0, 1);
        chk_held("bounce");
        chk("bounce_code_const", letter_code, 10'b0000000001);

        // Six dots overflow a five-slot letter
        for (int i = 0; i < 6; i++) press_sym(5, (i == 5) ? 40 : 5);
        chk_held("ovf");
        chk("ovf_code_const", letter_code, 10'b0101010101);
        chk("ovf_err_const", letter_err, 1'b1);

        // Overlong press aborts the pending dot; previous letter is kept
        press_sym(5, 8);
        press_sym(70, 40);
        chk_held("overlong");
        chk("overlong_code_const", letter_code, 10'b0101010101);

        // Random letters, with occasional overflow and overlong presses
        for (int l = 0; l < 15; l++) begin
            nsym = $urandom_range(6, 1);
            for (int s = 0; s < nsym; s++) begin
                if ($urandom_range(9, 0) == 0) p = $urandom_range(80, 70);
                else if ($urandom_range(1, 0) == 1) p = $urandom_range(9, 5);
                else p = $urandom_range(40, 16);
                g = (s == nsym - 1) ? $urandom_range(50, 40) : $urandom_range(20, 6);
                press_sym(p, g);
            end
        end
        chk_held("rand");

        // Reset mid-gap after two symbols discards the letter
        press_sym(6, 8);
        model_press(18);
        key(1'b1, 18);
        key(1'b0, 10);
        chk("mid_syms_done", exp_sym.size(), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        cur_dash.delete();
        cur_err  = 1'b0;
        last_let = '0;
        run_ticks(50);
        chk("mid_key_db", key_db, 0);
        chk("mid_letter_valid", letter_valid, 0);
        chk_held("mid_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
